led_pattern_ctrl: RTL and testbench

Button-driven LED pattern generator for the VC707 user LEDs, sitting directly downstream of the board clock input buffer and driving the GPIO LED pins. It replaces a single free-running blinker with a three-mode pattern engine (blink, binary count, scan) that advances at a fixed step rate derived from the board clock. A debounced pushbutton cycles the mode. An optional PWM stage dims the outputs.

---
 rtl/led_pattern_ctrl.sv | 157 +++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// Button-cycled LED pattern engine: blink, binary count and bounce-scan modes.
// Define LED_PATTERN_DIM_EN to add a 25% duty PWM dimmer on the outputs.
module led_pattern_ctrl #(
    parameter int CLK_HZ          = 200000000,
    parameter int STEP_HZ         = 4,
    parameter int NUM_LEDS        = 8,
    parameter int DEBOUNCE_CYCLES = 2000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn,
    output logic [NUM_LEDS-1:0] led
);

    localparam int STEP_DIV = CLK_HZ / STEP_HZ;
    localparam int PS_W     = $clog2(STEP_DIV);
    localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] MODE_BLINK = 2'd0;
    localparam logic [1:0] MODE_COUNT = 2'd1;
    localparam logic [1:0] MODE_SCAN  = 2'd2;

    localparam logic [NUM_LEDS-1:0] PAT_ONES = {NUM_LEDS{1'b1}};
    localparam logic [NUM_LEDS-1:0] PAT_ONE  = NUM_LEDS'(1);
    localparam logic [NUM_LEDS-1:0] PAT_TOP  = PAT_ONE << (NUM_LEDS - 1);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                btn_db_q, btn_db_d;
    logic                btn_prev_q, btn_prev_d;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic [1:0]          mode_q, mode_d;
    logic [PS_W-1:0]     ps_q, ps_d;
    logic [NUM_LEDS-1:0] pat_q, pat_d;
    logic                dir_up_q, dir_up_d;
    logic                press;
    logic                step;

    // Synchronizer and debouncer
    always_comb begin
        sync1_d    = btn;
        sync2_d    = sync1_q;
        btn_db_d   = btn_db_q;
        db_cnt_d   = db_cnt_q;
        btn_prev_d = btn_db_q;
        if (sync2_q == btn_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            btn_db_d = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    assign press = btn_db_q & ~btn_prev_q;
    assign step  = (ps_q == PS_LAST);

    // A press restarts the step period, so it also swallows a coincident step.
    always_comb begin
        mode_d   = mode_q;
        pat_d    = pat_q;
        dir_up_d = dir_up_q;
        ps_d     = step ? '0 : ps_q + PS_W'(1);
        if (press) begin
            ps_d = '0;
            unique case (mode_q)
                MODE_BLINK: begin
                    mode_d = MODE_COUNT;
                    pat_d  = '0;
                end
                MODE_COUNT: begin
                    mode_d   = MODE_SCAN;
                    pat_d    = PAT_ONE;
                    dir_up_d = 1'b1;
                end
                default: begin
                    mode_d = MODE_BLINK;
                    pat_d  = PAT_ONES;
                end
            endcase
        end else if (step) begin
            unique case (mode_q)
                MODE_BLINK: pat_d = ~pat_q;
                MODE_COUNT: pat_d = pat_q + PAT_ONE;
                MODE_SCAN: begin
                    if (dir_up_q) begin
                        if (pat_q == PAT_TOP) begin
                            pat_d    = pat_q >> 1;
                            dir_up_d = 1'b0;
                        end else begin
                            pat_d = pat_q << 1;
                        end
                    end else begin
                        if (pat_q == PAT_ONE) begin
                            pat_d    = pat_q << 1;
                            dir_up_d = 1'b1;
                        end else begin
                            pat_d = pat_q >> 1;
                        end
                    end
                end
                default: begin
                    mode_d = MODE_BLINK;
                    pat_d  = PAT_ONES;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            btn_db_q   <= 1'b0;
            btn_prev_q <= 1'b0;
            db_cnt_q   <= '0;
            mode_q     <= MODE_BLINK;
            ps_q       <= '0;
            pat_q      <= PAT_ONES;
            dir_up_q   <= 1'b1;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            btn_db_q   <= btn_db_d;
            btn_prev_q <= btn_prev_d;
            db_cnt_q   <= db_cnt_d;
            mode_q     <= mode_d;
            ps_q       <= ps_d;
            pat_q      <= pat_d;
            dir_up_q   <= dir_up_d;
        end
    end

`ifdef LED_PATTERN_DIM_EN
    logic [7:0] pwm_q, pwm_d;

    assign pwm_d = pwm_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    // pwm_q resets to 0, which is in the on-phase, so led still resets high.
    assign led = pat_q & {NUM_LEDS{pwm_q < 8'd64}};
`else
    assign led = pat_q;
`endif

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Randomized bench for led_pattern_ctrl against a step-count reference model.
module tb_led_pattern_ctrl;

    localparam int CLK  = 1000;
    localparam int SHZ  = 100;
    localparam int NL   = 4;
    localparam int DB   = 4;
    localparam int SDIV = CLK / SHZ;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          btn = 1'b0;
    logic [NL-1:0] led;

    int checks   = 0;
    int failures = 0;

    int m_mode, m_k, m_phase, m_run, m_pwm;
    bit m_s1, m_s2, m_db, m_pend;

    led_pattern_ctrl #(
        .CLK_HZ(CLK),
        .STEP_HZ(SHZ),
        .NUM_LEDS(NL),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .led(led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Pattern is a pure function of mode and steps taken since mode entry.
    function automatic logic [NL-1:0] exp_led();
        logic [NL-1:0] p;
        int pos;
        int idx;
        case (m_mode)
            0: p = (m_k % 2 == 0) ? {NL{1'b1}} : '0;
            1: p = NL'(m_k % (1 << NL));
            default: begin
                pos = m_k % (2 * NL - 2);
                idx = (pos < NL) ? pos : 2 * NL - 2 - pos;
                p   = NL'(1 << idx);
            end
        endcase
`ifdef LED_PATTERN_DIM_EN
        if (m_pwm >= 64) p = '0;
`endif
        return p;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_phase = 0; m_run = 0; m_pwm = 0;
        m_s1 = 0; m_s2 = 0; m_db = 0; m_pend = 0;
    endtask

    task automatic model_edge(input bit b);
        bit pr;
        pr = m_pend;
        m_pend = 0;
        if (m_s2 != m_db) begin
            m_run++;
            if (m_run == DB) begin
                m_db  = m_s2;
                m_run = 0;
                if (m_db) m_pend = 1;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = b;
        m_phase++;
        if (pr) begin
            m_mode  = (m_mode + 1) % 3;
            m_k     = 0;
            m_phase = 0;
        end else if (m_phase == SDIV) begin
            m_k++;
            m_phase = 0;
        end
        m_pwm = (m_pwm + 1) % 256;
    endtask

    task automatic cycle(input bit b);
        btn = b;
        @(posedge clk);
        model_edge(b);
        #1;
        check("led", led, exp_led());
    endtask

    task automatic do_reset();
        btn = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("rst_led", led, 4'hF);
    endtask

    task automatic push(input int hold);
        repeat (hold) cycle(1'b1);
        repeat (12) cycle(1'b0);
    endtask

    initial begin
        bit found;
        int v;
        int len;
        #2;
        do_reset();

        repeat (10) cycle(1'b0);
        check("blink_c10", led, 4'h0);
        repeat (10) cycle(1'b0);
        check("blink_c20", led, 4'hF);
        repeat (25) cycle(1'b0);

        push(10);
        repeat (SDIV * 17) cycle(1'b0);

        repeat (3) cycle(1'b1);
        repeat (30) cycle(1'b0);
        repeat (5) cycle(1'b1);
        repeat (10 * SDIV) cycle(1'b0);

        // Time a press onto the exact cycle a step would fire.
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_mode == 2 && m_phase == SDIV - 7) found = 1;
            else cycle(1'b0);
        end
        check("coll_wait", 16'(found), 16'd1);
        repeat (10) cycle(1'b1);
        repeat (3 * SDIV) cycle(1'b0);

        push(8);
        push(8);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            cycle(1'b0);
            if (m_mode == 2 && exp_led() != 4'hF) found = 1;
        end
        check("scan_wait", 16'(found), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", led, 4'hF);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("post_rst", led, 4'hF);

        for (int i = 0; i < 80; i++) begin
            v   = $urandom_range(0, 1);
            len = $urandom_range(1, 12);
            repeat (len) cycle(v[0]);
        end
        repeat (40) cycle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
